// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_RUN,
    S_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO; entry 0 is always the head, so the head is a plain register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t ent0, ent1;
  logic [1:0]   count;
  logic         pop_ok, push_ok;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new word lands behind whatever remains
          if (count == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives imem, queues words for decode.
//   state   | meaning
//   S_RUN   | fetching / redirecting / handing off to decode
//   S_FAULT | bad fetch address seen; idle until rst
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          QDEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            push, pop, flush;
  logic            q_full, q_empty;
  logic            in_range, misaligned;
  fetch_entry_t    q_din, q_head;

  assign imem_addr  = pc;
  assign in_range   = (pc[XLEN-1:2] < (XLEN-2)'(IMEM_WORDS));
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign out_valid  = (state == S_RUN) && !q_empty;
  assign pop        = out_valid && out_ready;
  assign fault      = (state == S_FAULT);
  assign out_instr  = q_head.instr;
  assign out_pc     = q_head.pc;
  assign q_din      = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (pop) fetch_count <= fetch_count + XLEN'(1);
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      S_RUN: begin
        if (redirect_valid) begin
          // the word read this cycle belongs to the old path and is dropped
          flush = 1'b1;
          if (misaligned) state_next = S_FAULT;
          else            pc_next    = redirect_pc;
        end else if (!q_full || pop) begin
          if (in_range) begin
            push    = 1'b1;
            pc_next = pc + XLEN'(4);
          end else begin
            state_next = S_FAULT;
            flush      = 1'b1;
          end
        end
      end
      S_FAULT: flush = 1'b1;
      default: flush = 1'b1;
    endcase
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural instruction memory.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_controller #(
    .XLEN(32), .RESET_PC(32'h0), .IMEM_WORDS(64), .QDEPTH(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    if (w == 32'd11) return 32'h0094_8663;
    return 32'hA500_0013 + (w << 8);
  endfunction

  always_comb begin
    imem_rdata = (imem_addr < 32'h100) ? mem_word(imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // streaming with decode always ready
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc",    out_pc, 32'(4 * i));
      chk("stream_instr", out_instr, mem_word(32'(i)));
      chk("stream_count", fetch_count, 32'(i));
    end

    // backpressure from reset: two entries fill, PC parks at 8
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_pc",    out_pc, 32'h0);
    chk("bp_instr", out_instr, mem_word(32'd0));
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_count", fetch_count, 32'd0);
    out_ready = 1'b1;
    step();
    chk("drain_pc",    out_pc, 32'h4);
    chk("drain_count", fetch_count, 32'd1);
    chk("drain_addr",  imem_addr, 32'hC);

    // redirect with 4/8 queued and a pop in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h2C;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr",  imem_addr, 32'h2C);
    chk("redir_count", fetch_count, 32'd2);
    step();
    chk("redir_tgt_valid", 32'(out_valid), 32'd1);
    chk("redir_tgt_pc",    out_pc, 32'h2C);
    chk("redir_tgt_instr", out_instr, 32'h0094_8663);
    chk("redir_tgt_count", fetch_count, 32'd2);

    // run off the end of memory
    for (int k = 1; k <= 52; k++) begin
      step();
      chk("range_pc", out_pc, 32'h2C + 32'(4 * k));
    end
    chk("range_last_instr", out_instr, mem_word(32'd63));
    step();
    chk("range_fault", 32'(fault), 32'd1);
    chk("range_valid", 32'(out_valid), 32'd0);
    chk("range_count", fetch_count, 32'd55);
    chk("range_addr",  imem_addr, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_addr",   imem_addr, 32'h100);
    chk("fault_valid",  32'(out_valid), 32'd0);

    // misaligned redirect with a full queue
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    chk("mis_pre_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    chk("mis_addr",  imem_addr, 32'h8);
    step();
    chk("mis_hold_valid", 32'(out_valid), 32'd0);

    // reset in the middle of a stream with a full queue
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("mid_pre_pc", out_pc, 32'h8);
    out_ready = 1'b0;
    step();
    chk("mid_full_addr", imem_addr, 32'h10);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_addr",  imem_addr, 32'h0);
    chk("mid_count", fetch_count, 32'd0);
    chk("mid_fault", 32'(fault), 32'd0);
    step();
    chk("mid_resume_pc",    out_pc, 32'h0);
    chk("mid_resume_instr", out_instr, mem_word(32'd0));
    step();
    chk("mid_resume_pc2",   out_pc, 32'h4);
    chk("mid_resume_count", fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer between the program counter and `instruction_mem`. It owns the PC and drives the instruction memory's word-aligned read address every cycle. It captures the combinational read data into a small queue and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects, flushing, and faulting on bad fetch addresses.

## Interface
- `XLEN`, 32: data and address width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `IMEM_WORDS`, 64: instruction memory depth in words; legal PCs are 0 .. 4*IMEM_WORDS-4.
- `QDEPTH`, 2: fetch queue entries; 2 is the only depth that must be supported.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  XLEN  byte address to `instruction_mem` `read_addr`; equals PC combinationally.
- `imem_rdata`  in  XLEN  combinational read data from `instruction_mem` `instruction_out`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  XLEN  target byte address.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  XLEN  head instruction.
- `out_pc`  out  XLEN  PC of head instruction.
- `fault`  out  1  sticky fetch fault.
- `fetch_count`  out  XLEN  number of completed out handshakes since reset; wraps modulo 2^XLEN.

## Operation
- FSM states: RUN and FAULT. Reset enters RUN.
- **RUN: fetch.** A fetch occurs in a cycle when all of the following hold:
  - the queue is not full, or a pop happens in the same cycle;
  - no redirect is active;
  - the PC is in range.
- **RUN: fetch effect.** At the edge, `{pc, imem_rdata}` is pushed and PC advances by 4.
- **RUN: out-of-range PC.** If the PC is out of range (`pc>>2 >= IMEM_WORDS`) and a fetch would occur, the next state is FAULT and nothing is pushed.
- **Redirect.** With `redirect_valid=1` in RUN:
  - the queue is flushed at the edge;
  - PC loads `redirect_pc`;
  - the memory word read that cycle is discarded.
- **Redirect and pop together.** A head handshake in the same cycle still counts as consumed, and `fetch_count` increments.
- **Misaligned redirect.** If `redirect_pc[1:0] != 0`, the state goes to FAULT, the queue is flushed, and PC is unchanged.
- **FAULT.** No fetches and no pushes. Queue is flushed, `out_valid=0`, `fault=1`. Redirects are ignored. Only `rst` exits FAULT.
- **Pop.** A pop occurs when `out_valid && out_ready`, and the head advances.
- **Full queue.** When the queue is full and no pop occurs, fetch stalls and PC holds.
- **Simultaneous push and pop.** With a full queue, push and pop in one cycle are both allowed; occupancy stays the same.
- **PC arithmetic.** Modulo 2^XLEN. The in-range check catches wrap-around.

## Timing
- **Reset values (edge with `rst=1`):**
  - PC=`RESET_PC`, so `imem_addr`=`RESET_PC`;
  - queue empty, `out_valid=0`;
  - `out_instr=0`, `out_pc=0`;
  - `fault=0`, `fetch_count=0`.
- **Reset mid-operation.** All of the above values take effect at that edge, regardless of state, redirect or handshake.
- **Fetch latency.**
  - A fetch issued in cycle t is visible at the out port in cycle t+1.
  - With `out_ready` held high, throughput is 1 instruction per cycle.
- **Redirect latency.**
  - Redirect asserted in cycle t: `imem_addr=redirect_pc` in t+1.
  - First target instruction appears at the out port in t+2.
  - `out_valid=0` in t+1.
- **Fault timing.** `fault` rises the cycle after the triggering edge. `out_valid` is 0 in that same cycle.
- **Output stability.** `out_instr`/`out_pc` are held stable while `out_valid && !out_ready`.
- **Registered vs combinational.**
  - `imem_addr` is the only combinational output, decoded from the PC register.
  - There are no combinational paths from the input ports to any output.

## Structure
- **Package `fetch_pkg`:**
  - state enum `{S_RUN, S_FAULT}`;
  - `XLEN`;
  - `NOP_INSTR = 32'h0000_0013`;
  - a `fetch_entry_t` struct `{pc, instr}`.
- **Sub-module `fetch_queue`:**
  - 2-entry FIFO of `fetch_entry_t`;
  - push/pop/flush inputs, full/empty outputs;
  - flush has priority over push.
- **Top level.** `fetch_controller` holds the PC, FSM, fault logic and counter.

## Test plan
- **Stream.** Reset with `RESET_PC=0` and `out_ready=1`. Expected: `out_pc` 0,4,8,… on consecutive cycles starting the cycle after reset is released; `out_instr` equals memory words 0,1,2,…; `fetch_count` increments each cycle.
- **Backpressure.** Hold `out_ready=0` for 5 cycles. Expected: exactly 2 entries fill and PC stalls at 8; `out_pc=0` holds. On release, PCs 0,4,8 drain in order with no loss or duplication.
- **Redirect.** Assert `redirect_valid` with `redirect_pc=32'h2C` while entries at 4/8 are queued. Expected: `out_valid=0` the next cycle, then `out_pc=0x2C` with `out_instr=32'h00948663` (memory word 11). A pop in the redirect cycle increments `fetch_count`.
- **Fault (range).** Run sequentially to PC=0x100 with `IMEM_WORDS=64`. Expected: the last delivered `out_pc=0xFC`, then `fault=1` and `out_valid=0`. A later redirect is ignored until `rst`.
- **Fault (misaligned).** `redirect_pc=32'h0000_0006`. Expected: `fault=1` the next cycle and the queue empty.
- **Mid-run reset.** Assert `rst` for one cycle during a stream with a full queue. Expected: next cycle `out_valid=0`, `imem_addr=0`, `fetch_count=0`; streaming resumes from PC 0.
